lenet_feeder: RTL and testbench
===============================

LENET_FEEDER -- requirements
Module: lenet_feeder

Interface
REQ-001 Parameter: BUF_SIDE, 32, side length of the square LeNet input buffer; the buffer holds BUF_SIDE*BUF_SIDE = 1024 bytes, with the 28x28 image at offset row 2, column 2.
REQ-002 Parameter: DROP_W, 8, width of the dropped-frame counter.
REQ-003 Port: clk25, in, 1, pixel clock; the only clock.
REQ-004 Port: rst_n, in, 1, reset, asynchronous and active-low.
REQ-005 Port: data_ready, in, 1, single-cycle pulse from the preprocessing core meaning the LeNet buffer frame is complete.
REQ-006 Port: rd_en, out, 1, read strobe to the LeNet buffer RAM.
REQ-007 Port: rd_addr, out, 10, read address, row-major (row*BUF_SIDE + col).
REQ-008 Port: rd_data, in, 8, RAM read data, valid exactly 1 cycle after rd_en.
REQ-009 Port: m_valid, out, 1, stream data valid.
REQ-010 Port: m_ready, in, 1, downstream ready.
REQ-011 Port: m_data, out, 8, stream byte.
REQ-012 Port: m_last, out, 1, high on beat 1023 of the frame.
REQ-013 Port: busy, out, 1, high whenever the state is not IDLE.
REQ-014 Port: frame_done, out, 1, one-cycle pulse after the last beat is accepted.
REQ-015 Port: drop_cnt, out, DROP_W, saturating count of ignored data_ready pulses.

Function
REQ-016 FSM states: IDLE, STREAM.
- IDLE -> STREAM on data_ready=1.
- STREAM -> IDLE on the clock edge where the beat with m_last=1 handshakes (m_valid & m_ready).
REQ-017 Fetch counter (11 bit): cleared on entry to STREAM, incremented on each rd_en.
- rd_addr = fetch counter[9:0].
- rd_en = 0 once 1024 reads have been issued.
REQ-018 Output buffer: 2-entry FIFO.
- RAM data is written into the FIFO in the cycle after rd_en.
- m_valid = FIFO not empty; m_data and m_last come from the FIFO head.
REQ-019 rd_en is combinational and SHALL assert in STREAM only when fetch < 1024 and (fifo_count + inflight - pop) < 2, where pop = m_valid & m_ready.
- This guarantees the FIFO never overflows.
- Sustained throughput is 1 beat/cycle while m_ready stays high.
REQ-020 Latency: with data_ready high in cycle 0 and m_ready held high:
- cycle 1: rd_en=1, rd_addr=0;
- cycle 3: m_valid=1, m_data = byte 0;
- cycle 1026: beat 1023 is presented with m_last=1.
REQ-021 While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable and m_valid SHALL stay high.
REQ-022 m_last SHALL be 1 only on beat index 1023 (tracked by an output beat counter, not the fetch counter).
REQ-023 frame_done SHALL be 1 for exactly the cycle following the final handshake; the state is IDLE in that cycle.
REQ-024 A data_ready pulse while the state is STREAM (including the cycle of the final handshake) SHALL be ignored and SHALL increment drop_cnt, which holds at 2^DROP_W-1.
REQ-025 A data_ready pulse in the frame_done cycle SHALL start a new frame normally.
REQ-026 m_valid SHALL never assert in IDLE; the FIFO and counters SHALL be empty or cleared on entry to STREAM.

Reset
REQ-027 rst_n=0 SHALL asynchronously force:
- state = IDLE;
- FIFO empty;
- fetch and beat counters = 0;
- rd_en=0, rd_addr=0, m_valid=0, m_data=0, m_last=0, busy=0, frame_done=0, drop_cnt=0.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no further handshake.
- After release, the block SHALL wait in IDLE for the next data_ready.

Verification
REQ-029 Full-rate frame: RAM model with byte = addr[7:0], data_ready at cycle 0, m_ready=1 -> 1024 beats in consecutive cycles 3..1026 with values 0..255 repeating, m_last only on the final beat, frame_done at cycle 1027.
REQ-030 Backpressure: m_ready random at 50%, plus a 20-cycle low stretch -> byte order is exact, no beat is lost or duplicated, data stays stable while stalled, and the FIFO never exceeds 2 entries.
REQ-031 Overlapping frame: second data_ready at cycle 500 -> drop_cnt=1, the stream is unaffected, and busy stays 1 until the frame ends.
REQ-032 Back-to-back frames: data_ready in the frame_done cycle -> a second full 1024-beat frame starts with rd_addr=0 one cycle later, and drop_cnt is unchanged.
REQ-033 Saturation: 300 data_ready pulses during one frame -> drop_cnt=255.
REQ-034 Mid-frame reset: rst_n low at beat 400, released 3 cycles later -> all outputs are 0 immediately; a subsequent data_ready streams a full frame from byte 0.

Source files
------------

// File: rtl/lenet_feeder_if.sv
// Bus bundle between the LeNet frame feeder, its buffer RAM read port and the
// downstream byte stream.
interface lenet_feeder_if;
  logic       rd_en;
  logic [9:0] rd_addr;
  logic [7:0] rd_data;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;

  modport master (
    output rd_en, rd_addr, m_valid, m_data, m_last,
    input  rd_data, m_ready
  );

  modport slave (
    input  rd_en, rd_addr, m_valid, m_data, m_last,
    output rd_data, m_ready
  );
endinterface

// File: rtl/lenet_feeder.sv
// Streams a completed LeNet input buffer (BUF_SIDE x BUF_SIDE bytes) out of RAM
// as a valid/ready byte stream through a 2-entry skid FIFO.
module lenet_feeder #(
  parameter int BUF_SIDE = 32,
  parameter int DROP_W   = 8
) (
  input  logic              clk25,
  input  logic              rst_n,
  input  logic              data_ready,
  lenet_feeder_if.master    bus,
  output logic              busy,
  output logic              frame_done,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int FRAME = BUF_SIDE * BUF_SIDE;
  localparam int AW    = $clog2(FRAME);

  typedef enum logic {IDLE, STREAM} state_e;

  state_e            state_q, state_d;
  logic [AW:0]       fetch_q, fetch_d;
  logic [AW-1:0]     beat_q, beat_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        count_q, count_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [7:0]        slot0_q, slot1_q;
  logic              done_q, done_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  logic valid;
  logic pop;
  logic last_beat;
  logic rd_en;

  // A read is only issued if its byte is guaranteed a FIFO slot when it lands.
  always_comb begin
    valid     = (count_q != 2'd0);
    pop       = valid & bus.m_ready;
    last_beat = (beat_q == AW'(FRAME - 1));
    rd_en     = (state_q == STREAM) &&
                (fetch_q < (AW+1)'(FRAME)) &&
                ((3'(count_q) + 3'(inflight_q)) < (3'd2 + 3'(pop)));
  end

  assign bus.rd_en   = rd_en;
  assign bus.rd_addr = 10'(fetch_q[AW-1:0]);
  assign bus.m_valid = valid;
  assign bus.m_data  = valid ? (rd_ptr_q ? slot1_q : slot0_q) : 8'd0;
  assign bus.m_last  = valid & last_beat;
  assign busy        = (state_q == STREAM);
  assign frame_done  = done_q;
  assign drop_cnt    = drop_q;

  always_comb begin
    state_d    = state_q;
    fetch_d    = fetch_q;
    beat_d     = beat_q;
    inflight_d = rd_en;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    done_d     = 1'b0;
    drop_d     = drop_q;
    unique case (state_q)
      IDLE: begin
        if (data_ready) begin
          state_d  = STREAM;
          fetch_d  = '0;
          beat_d   = '0;
          count_d  = '0;
          wr_ptr_d = 1'b0;
          rd_ptr_d = 1'b0;
        end
      end
      STREAM: begin
        if (data_ready && (drop_q != '1)) drop_d = drop_q + DROP_W'(1);
        if (rd_en) fetch_d = fetch_q + (AW+1)'(1);
        if (inflight_q) wr_ptr_d = ~wr_ptr_q;
        if (pop) begin
          rd_ptr_d = ~rd_ptr_q;
          beat_d   = beat_q + AW'(1);
        end
        count_d = count_q + 2'(inflight_q) - 2'(pop);
        if (pop && last_beat) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk25 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_q    <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      slot0_q    <= '0;
      slot1_q    <= '0;
      done_q     <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_q    <= fetch_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      done_q     <= done_d;
      drop_q     <= drop_d;
      if ((state_q == STREAM) && inflight_q) begin
        if (wr_ptr_q) slot1_q <= bus.rd_data;
        else          slot0_q <= bus.rd_data;
      end
    end
  end

endmodule

// File: tb/tb_lenet_feeder.sv
// Scoreboard bench for lenet_feeder: frames are queued as expected beats when
// started, and a free-running monitor checks every accepted beat against them.
module tb_lenet_feeder;

  logic       clk25 = 1'b0;
  logic       rst_n = 1'b0;
  logic       data_ready = 1'b0;
  logic       busy;
  logic       frame_done;
  logic [7:0] drop_cnt;

  lenet_feeder_if bus();

  lenet_feeder #(.BUF_SIDE(32), .DROP_W(8)) dut (
    .clk25      (clk25),
    .rst_n      (rst_n),
    .data_ready (data_ready),
    .bus        (bus),
    .busy       (busy),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk25 = ~clk25;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  int    total = 0;
  int    bad = 0;
  beat_t expQ[$];
  bit    modelActive = 0;
  int    expDrop = 0;
  int    beatsSeen = 0;
  int    readyMode = 0;

  // Buffer RAM model: every byte equals the low 8 bits of its address.
  always @(posedge clk25) begin
    if (bus.rd_en) bus.rd_data <= bus.rd_addr[7:0];
  end

  // Downstream ready: 0 = always ready, 1 = random 50%, 2 = held low.
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk25);
      #1;
      case (readyMode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = 1'($urandom_range(0, 1));
        default: bus.m_ready = 1'b0;
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One-cycle data_ready pulse; the model decides whether it starts a frame or is dropped.
  task automatic applyStimulus();
    beat_t b;
    @(posedge clk25);
    #1;
    if (modelActive) begin
      if (expDrop < 255) expDrop++;
    end else begin
      modelActive = 1;
      beatsSeen = 0;
      for (int i = 0; i < 1024; i++) begin
        b.data = i[7:0];
        b.last = (i == 1023);
        expQ.push_back(b);
      end
    end
    data_ready = 1'b1;
    @(posedge clk25);
    #1;
    data_ready = 1'b0;
  endtask

  task automatic waitDone(input int maxCyc);
    int n = 0;
    int gaps = 0;
    bit seen = 0;
    while (!seen && n < maxCyc) begin
      @(negedge clk25);
      n++;
      if (frame_done) seen = 1;
      else if (!busy) gaps++;
    end
    checkOutput("frame_done_seen", 32'(seen), 32'd1);
    checkOutput("busy_gap", 32'(gaps), 32'd0);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    checkOutput("drop_cnt", 32'(drop_cnt), 32'(expDrop));
  endtask

  // Monitor: compares accepted beats, stall stability and frame_done timing.
  logic       prevStall = 1'b0;
  logic [7:0] prevData = 8'd0;
  logic       prevLast = 1'b0;
  logic       prevFinal = 1'b0;

  always @(negedge clk25) begin
    beat_t e;
    if (!rst_n) begin
      prevStall = 1'b0;
      prevFinal = 1'b0;
    end else begin
      if (frame_done || prevFinal) checkOutput("frame_done_timing", 32'(frame_done), 32'(prevFinal));
      if (bus.m_valid && !busy) checkOutput("valid_in_idle", 32'(bus.m_valid), 32'd0);
      if (prevStall) begin
        checkOutput("stall_valid", 32'(bus.m_valid), 32'd1);
        checkOutput("stall_data", 32'(bus.m_data), 32'(prevData));
        checkOutput("stall_last", 32'(bus.m_last), 32'(prevLast));
      end
      prevFinal = 1'b0;
      if (bus.m_valid && bus.m_ready) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL extra_beat: got data 0x%0h, expected no beat", bus.m_data);
        end else begin
          e = expQ.pop_front();
          checkOutput("beat_data", 32'(bus.m_data), 32'(e.data));
          checkOutput("beat_last", 32'(bus.m_last), 32'(e.last));
          beatsSeen++;
          if (e.last) begin
            modelActive = 0;
            prevFinal = 1'b1;
          end
        end
      end
      prevStall = bus.m_valid && !bus.m_ready;
      prevData  = bus.m_data;
      prevLast  = bus.m_last;
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_rd_en"}, 32'(bus.rd_en), 32'd0);
    checkOutput({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'd0);
    checkOutput({tag, "_m_valid"}, 32'(bus.m_valid), 32'd0);
    checkOutput({tag, "_m_data"}, 32'(bus.m_data), 32'd0);
    checkOutput({tag, "_m_last"}, 32'(bus.m_last), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    checkOutput({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
  endtask

  initial begin
    int gaps;
    int n;

    // Power-on reset
    #1;
    checkAllZero("reset");
    repeat (3) @(posedge clk25);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk25);

    // Full-rate frame with cycle-exact latency checks
    $display("[TB] full-rate frame");
    readyMode = 0;
    gaps = 0;
    applyStimulus();
    for (int k = 1; k <= 1027; k++) begin
      @(negedge clk25);
      if (k == 1) begin
        checkOutput("c1_rd_en", 32'(bus.rd_en), 32'd1);
        checkOutput("c1_rd_addr", 32'(bus.rd_addr), 32'd0);
      end
      if (k == 2) checkOutput("c2_m_valid", 32'(bus.m_valid), 32'd0);
      if (k == 3) begin
        checkOutput("c3_m_valid", 32'(bus.m_valid), 32'd1);
        checkOutput("c3_m_data", 32'(bus.m_data), 32'd0);
      end
      if (k >= 3 && k <= 1026 && !bus.m_valid) gaps++;
      if (k == 1026) checkOutput("c1026_m_last", 32'(bus.m_last), 32'd1);
      if (k == 1027) begin
        checkOutput("c1027_frame_done", 32'(frame_done), 32'd1);
        checkOutput("c1027_busy", 32'(busy), 32'd0);
      end
    end
    checkOutput("fullrate_gaps", 32'(gaps), 32'd0);
    checkOutput("fullrate_drained", 32'(expQ.size()), 32'd0);

    // Random backpressure plus a 20-cycle stall
    $display("[TB] backpressure frame");
    readyMode = 1;
    applyStimulus();
    repeat (200) @(posedge clk25);
    readyMode = 2;
    repeat (20) @(posedge clk25);
    readyMode = 1;
    waitDone(6000);
    readyMode = 0;
    repeat (2) @(posedge clk25);

    // Overlapping request mid-frame is dropped
    $display("[TB] overlapping request");
    applyStimulus();
    repeat (498) @(posedge clk25);
    applyStimulus();
    waitDone(1100);

    // Back-to-back: restart in the frame_done cycle
    $display("[TB] back-to-back frames");
    applyStimulus();
    n = 0;
    while (!(bus.m_valid && bus.m_ready && bus.m_last) && n < 1100) begin
      @(negedge clk25);
      n++;
    end
    checkOutput("b2b_last_seen", 32'(n < 1100), 32'd1);
    applyStimulus();
    @(negedge clk25);
    checkOutput("b2b_rd_en", 32'(bus.rd_en), 32'd1);
    checkOutput("b2b_rd_addr", 32'(bus.rd_addr), 32'd0);
    waitDone(1100);

    // Drop counter saturation
    $display("[TB] drop saturation");
    applyStimulus();
    repeat (300) applyStimulus();
    waitDone(1100);
    checkOutput("sat_drop_cnt", 32'(drop_cnt), 32'd255);

    // Reset in the middle of a frame
    $display("[TB] mid-frame reset");
    applyStimulus();
    n = 0;
    while (beatsSeen < 400 && n < 1100) begin
      @(negedge clk25);
      n++;
    end
    checkOutput("reset_point_reached", 32'(beatsSeen >= 400), 32'd1);
    @(posedge clk25);
    #1;
    rst_n = 1'b0;
    expQ.delete();
    modelActive = 0;
    expDrop = 0;
    #1;
    checkAllZero("midreset");
    repeat (3) @(posedge clk25);
    #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk25);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
    checkOutput("post_reset_valid", 32'(bus.m_valid), 32'd0);
    applyStimulus();
    waitDone(1100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
